// File: rtl/cte_pkg.sv
// Shared constants and types for the CTE RGB-to-YUV 4:2:2 encoder.
// Coefficients are scaled by 2^8; rounding and chroma offsets are 128.
package cte_pkg;

  localparam int Y_R = 77;
  localparam int Y_G = 150;
  localparam int Y_B = 29;

  localparam int U_R = -43;
  localparam int U_G = -85;
  localparam int U_B = 128;

  localparam int V_R = 128;
  localparam int V_G = -107;
  localparam int V_B = -21;

  localparam int RND   = 128;
  localparam int C_OFS = 128;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LUMA
  } state_e;

  typedef enum logic {
    EVEN,
    ODD
  } parity_e;

  function automatic logic [7:0] sat8(input int v);
    logic [7:0] r;
    if (v < 0)
      r = 8'd0;
    else if (v > 255)
      r = 8'd255;
    else
      r = v[7:0];
    return r;
  endfunction

endpackage

// File: rtl/rgb2yuv_matrix.sv
// Combinational RGB to YUV colour matrix with rounding and
// saturation of each component to 0..255.
module rgb2yuv_matrix
  import cte_pkg::*;
#(
  parameter int FRAC = 8
) (
  input  logic [23:0] rgb,
  output logic [7:0]  y,
  output logic [7:0]  u,
  output logic [7:0]  v
);

  int r;
  int g;
  int b;
  int y_acc;
  int u_acc;
  int v_acc;

  always_comb begin
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
    y_acc = Y_R * r + Y_G * g + Y_B * b + RND;
    u_acc = U_R * r + U_G * g + U_B * b + RND;
    v_acc = V_R * r + V_G * g + V_B * b + RND;
    y = sat8(y_acc >>> FRAC);
    u = sat8((u_acc >>> FRAC) + C_OFS);
    v = sat8((v_acc >>> FRAC) + C_OFS);
  end

endmodule

// File: rtl/cte_rgb2yuv.sv
// RGB-to-YUV 4:2:2 encoder: one pixel in per handshake, bytes out
// in U Y V Y order, chroma sampled from the even pixel of each pair.
module cte_rgb2yuv
  import cte_pkg::*;
#(
  parameter int DW   = 8,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_en,
  input  logic [3*DW-1:0] rgb_in,
  output logic            busy,
  output logic            out_valid,
  output logic [DW-1:0]   yuv_out
);

  state_e          state_q, state_d;
  parity_e         par_q, par_d;
  logic [3*DW-1:0] pix_q, pix_d;
  logic [DW-1:0]   y_hold_q, y_hold_d;
  logic [DW-1:0]   v_hold_q, v_hold_d;
  logic [DW-1:0]   yuv_q, yuv_d;
  logic            valid_q, valid_d;

  logic [7:0] y_c;
  logic [7:0] u_c;
  logic [7:0] v_c;
  logic       accept;

  rgb2yuv_matrix #(
    .FRAC (FRAC)
  ) u_matrix (
    .rgb (pix_q),
    .y   (y_c),
    .u   (u_c),
    .v   (v_c)
  );

  assign busy      = (state_q == CONV);
  assign accept    = in_en && !busy;
  assign out_valid = valid_q;
  assign yuv_out   = yuv_q;

  always_comb begin
    state_d  = state_q;
    par_d    = par_q;
    pix_d    = pix_q;
    y_hold_d = y_hold_q;
    v_hold_d = v_hold_q;
    yuv_d    = yuv_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pix_d   = rgb_in;
          state_d = CONV;
        end
      end
      CONV: begin
        // Odd pixel reuses the V sampled from its even partner
        yuv_d    = (par_q == EVEN) ? u_c : v_hold_q;
        valid_d  = 1'b1;
        y_hold_d = y_c;
        if (par_q == EVEN)
          v_hold_d = v_c;
        state_d  = LUMA;
      end
      LUMA: begin
        yuv_d   = y_hold_q;
        valid_d = 1'b1;
        par_d   = (par_q == EVEN) ? ODD : EVEN;
        if (accept) begin
          pix_d   = rgb_in;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      par_q    <= EVEN;
      pix_q    <= '0;
      y_hold_q <= '0;
      v_hold_q <= '0;
      yuv_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_q    <= par_d;
      pix_q    <= pix_d;
      y_hold_q <= y_hold_d;
      v_hold_q <= v_hold_d;
      yuv_q    <= yuv_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_cte_rgb2yuv.sv
// Self-checking bench for cte_rgb2yuv: a cycle-scheduled byte model
// checked every cycle, plus literal byte lists for directed vectors.
module tb_cte_rgb2yuv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_en = 1'b0;
  logic [23:0] rgb_in = 24'h0;
  logic        busy;
  logic        out_valid;
  logic [7:0]  yuv_out;

  always #5 clk = ~clk;

  cte_rgb2yuv dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .rgb_in    (rgb_in),
    .busy      (busy),
    .out_valid (out_valid),
    .yuv_out   (yuv_out)
  );

  int checks = 0;
  int failures = 0;

  bit         started = 0;
  bit         mbusy = 0;
  bit         mpar = 0;
  bit         macc = 0;
  logic [7:0] mvhold = 8'h0;
  bit         mvalid = 0;
  logic [7:0] mbyte = 8'h0;
  logic [7:0] sched [int];
  int         edge_n = 0;
  int         acc_count = 0;
  int         byte_count = 0;
  logic [7:0] got [$];

  function automatic logic [7:0] clamp(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic logic [7:0] ref_y(input logic [23:0] p);
    int r = p[23:16];
    int g = p[15:8];
    int b = p[7:0];
    return clamp((77 * r + 150 * g + 29 * b + 128) >>> 8);
  endfunction

  function automatic logic [7:0] ref_u(input logic [23:0] p);
    int r = p[23:16];
    int g = p[15:8];
    int b = p[7:0];
    return clamp(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128);
  endfunction

  function automatic logic [7:0] ref_v(input logic [23:0] p);
    int r = p[23:16];
    int g = p[15:8];
    int b = p[7:0];
    return clamp(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128);
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h",
               n, edge_n, act, exp);
    end
  endtask

  // Model: an accept at edge e schedules chroma at e+1 and luma at e+2.
  always @(posedge clk) begin
    edge_n++;
    started = 1;
    if (reset) begin
      mbusy = 0;
      mpar = 0;
      mvhold = 8'h0;
      mvalid = 0;
      mbyte = 8'h0;
      sched.delete();
    end else begin
      macc = in_en && !mbusy;
      if (sched.exists(edge_n)) begin
        mvalid = 1;
        mbyte = sched[edge_n];
        sched.delete(edge_n);
      end else begin
        mvalid = 0;
      end
      if (macc) begin
        if (!mpar) begin
          sched[edge_n + 1] = ref_u(rgb_in);
          mvhold = ref_v(rgb_in);
        end else begin
          sched[edge_n + 1] = mvhold;
        end
        sched[edge_n + 2] = ref_y(rgb_in);
        mpar = !mpar;
        acc_count++;
      end
      mbusy = macc;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", int'(busy), int'(mbusy));
      chk("out_valid", int'(out_valid), int'(mvalid));
      chk("yuv_out", int'(yuv_out), int'(mbyte));
      if (out_valid) begin
        got.push_back(yuv_out);
        byte_count++;
      end
    end
  end

  task automatic send(input logic [23:0] p);
    @(negedge clk);
    in_en = 1'b1;
    rgb_in = p;
    @(negedge clk);
    in_en = 1'b0;
    rgb_in = 24'h5A5A5A;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_q(input string n, input logic [7:0] e [$]);
    chk({n, "_count"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", n, i), int'(got[i]), int'(e[i]));
  endtask

  logic [7:0]  exp_q [$];
  logic [23:0] hold_pix [4];
  int a0;
  int b0;
  bit done;

  initial begin
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_yuv", int'(yuv_out), 0);

    got.delete();
    send(24'hFFFFFF);
    send(24'h000000);
    idle(4);
    exp_q = {8'h80, 8'hFF, 8'h80, 8'h00};
    check_q("white_black", exp_q);

    got.delete();
    send(24'hFF0000);
    send(24'h0000FF);
    idle(4);
    exp_q = {8'h55, 8'h4D, 8'hFF, 8'h1D};
    check_q("red_blue", exp_q);

    got.delete();
    hold_pix = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h0000FF};
    a0 = acc_count;
    b0 = byte_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_en = 1'b1;
      rgb_in = hold_pix[i];
      @(negedge clk);
      rgb_in = 24'h123456 + 24'(i);
    end
    @(negedge clk);
    in_en = 1'b0;
    idle(4);
    chk("hold_captures", acc_count - a0, 4);
    chk("hold_bytes", byte_count - b0, 8);
    exp_q = {8'h80, 8'hFF, 8'h80, 8'h00,
             8'h55, 8'h4D, 8'hFF, 8'h1D};
    check_q("hold", exp_q);

    got.delete();
    send(24'hFFFFFF);
    idle(5);
    send(24'h0000FF);
    idle(4);
    exp_q = {8'h80, 8'hFF, 8'h80, 8'h1D};
    check_q("stall", exp_q);

    got.delete();
    @(negedge clk);
    in_en = 1'b1;
    rgb_in = 24'hFFFFFF;
    @(negedge clk);
    in_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_valid", int'(out_valid), 0);
    chk("midreset_yuv", int'(yuv_out), 0);
    send(24'h000000);
    idle(4);
    exp_q = {8'h80, 8'h80, 8'h00};
    check_q("midreset", exp_q);

    do_reset();
    a0 = acc_count;
    b0 = byte_count;
    done = 0;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clk);
      if (acc_count - a0 >= 500) begin
        in_en = 1'b0;
        done = 1;
      end else begin
        in_en = ($urandom_range(0, 3) != 0);
        rgb_in = 24'($urandom);
      end
    end
    in_en = 1'b0;
    idle(5);
    chk("random_captures", acc_count - a0, 500);
    chk("random_bytes", byte_count - b0, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
